fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 21 ++
 rtl/fetch_sequencer_if.sv | 11 +
 rtl/fetch_timeout_counter.sv | 25 ++
 rtl/fetch_sequencer.sv | 88 ++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer: FSM state encoding,
// default halt opcode and the halt-decode helper.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_HALT  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    localparam logic [5:0] HALT_OPCODE_DEF = 6'b111111;
    localparam logic [7:0] TIMEOUT_DEF     = 8'd64;

    // True when the instruction's major opcode field is the halt opcode.
    function automatic logic is_halt(input logic [31:0] word, input logic [5:0] opcode);
        return word[31:26] == opcode;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and the instruction memory (slave).
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive cycles spent waiting for the instruction memory and
// flags the last permitted cycle of the wait.
module fetch_timeout_counter #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tc
);
    logic [7:0] count;

    // Advance while waiting, snap back to zero whenever the wait ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (run) begin
            count <= count + 8'd1;
        end else begin
            count <= '0;
        end
    end

    assign tc = (count == TIMEOUT - 8'd1);
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests a word from instruction memory,
// presents it to the datapath, gates one PC update per retired instruction,
// and stops on a halt opcode or a memory timeout.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter logic [7:0] TIMEOUT     = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         pc,
    input  logic                stall_in,
    fetch_sequencer_if.master   imem,
    output logic                pc_hold,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [31:0]         instr_count,
    output logic                halted,
    output logic                timeout_err
);
    fetch_state_t state;
    logic [31:0]  instr_q;
    logic [31:0]  count_q;
    logic         in_req;
    logic         retire;
    logic         halt_op;
    logic         wait_tc;

    assign in_req  = (state == ST_REQ);
    assign retire  = (state == ST_ISSUE) && !stall_in;
    assign halt_op = is_halt(instr_q, HALT_OPCODE);

    fetch_timeout_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .run   (in_req),
        .tc    (wait_tc)
    );

    // Fetch FSM plus the captured instruction and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            instr_q <= '0;
            count_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_REQ;
                end
                ST_REQ: begin
                    // An ack wins over a coincident timeout.
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        state   <= ST_ISSUE;
                    end else if (wait_tc) begin
                        state <= ST_ERR;
                    end
                end
                ST_ISSUE: begin
                    if (!stall_in) begin
                        count_q <= count_q + 32'd1;
                        state   <= halt_op ? ST_HALT : ST_REQ;
                    end
                end
                ST_HALT: state <= ST_HALT;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign imem.imem_req  = in_req;
    assign imem.imem_addr = in_req ? pc : 32'd0;

    // The PC may advance only on the edge that retires a non-halt
    // instruction, so the release is qualified by stall_in in the same
    // cycle; the next REQ then already sees the updated PC.
    assign pc_hold = !(retire && !halt_op);

    assign instr       = instr_q;
    assign instr_valid = (state == ST_ISSUE);
    assign instr_count = count_q;
    assign halted      = (state == ST_HALT);
    assign timeout_err = (state == ST_ERR);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-by-cycle vector table for the
// normal fetch/stall/halt flow, then hand sequences for reset, timeout and
// counter wrap.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        pc_hold, instr_valid, halted, timeout_err;
    logic [31:0] instr, instr_count;

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer_if bus();

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .stall_in    (stall_in),
        .imem        (bus.master),
        .pc_hold     (pc_hold),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_count (instr_count),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start, stall, ack;
        logic [31:0] pc, rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_hold, e_iv;
        logic [31:0] e_instr, e_cnt;
        logic        e_halt, e_terr;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    function automatic vec_t mk(logic st, logic sl, logic ak, logic [31:0] p, logic [31:0] rd,
                                logic rq, logic [31:0] ad, logic hd, logic iv,
                                logic [31:0] ins, logic [31:0] cn, logic hl, logic te);
        vec_t v;
        v.start = st; v.stall = sl; v.ack = ak; v.pc = p; v.rdata = rd;
        v.e_req = rq; v.e_addr = ad; v.e_hold = hd; v.e_iv = iv;
        v.e_instr = ins; v.e_cnt = cn; v.e_halt = hl; v.e_terr = te;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic ak,
                         input logic [31:0] p, input logic [31:0] rd);
        start = st; stall_in = sl; bus.imem_ack = ak; pc = p; bus.imem_rdata = rd;
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic [31:0] ad,
                              input logic hd, input logic iv, input logic [31:0] ins,
                              input logic [31:0] cn, input logic hl, input logic te);
        vectors++;
        chk({tag, ".imem_req"},    32'(bus.imem_req),  32'(rq));
        chk({tag, ".imem_addr"},   bus.imem_addr,      ad);
        chk({tag, ".pc_hold"},     32'(pc_hold),       32'(hd));
        chk({tag, ".instr_valid"}, 32'(instr_valid),   32'(iv));
        chk({tag, ".instr"},       instr,              ins);
        chk({tag, ".instr_count"}, instr_count,        cn);
        chk({tag, ".halted"},      32'(halted),        32'(hl));
        chk({tag, ".timeout_err"}, 32'(timeout_err),   32'(te));
    endtask

    // Watchdog so a wedged run still ends with a visible failure.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'd0;

        //            st sl ak pc            rdata           req addr          hold iv instr          cnt    hl te
        vecs[0]  = mk(0, 0, 1, 32'h1000, 32'hDEAD_BEEF,  0, 32'h0,     1, 0, 32'h0,          32'd0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 32'h1004, 32'h0,          0, 32'h0,     1, 0, 32'h0,          32'd0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 32'h1008, 32'h0,          1, 32'h1008,  1, 0, 32'h0,          32'd0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 32'h1008, 32'h1234_5678,  1, 32'h1008,  1, 0, 32'h0,          32'd0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h1008, 32'h0,          0, 32'h0,     0, 1, 32'h1234_5678,  32'd0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 32'h100C, 32'hA5A5_0001,  1, 32'h100C,  1, 0, 32'h1234_5678,  32'd1, 0, 0);
        vecs[6]  = mk(0, 1, 0, 32'h100C, 32'h0,          0, 32'h0,     1, 1, 32'hA5A5_0001,  32'd1, 0, 0);
        vecs[7]  = mk(0, 1, 0, 32'h100C, 32'h0,          0, 32'h0,     1, 1, 32'hA5A5_0001,  32'd1, 0, 0);
        vecs[8]  = mk(0, 1, 1, 32'h100C, 32'hFFFF_FFFF,  0, 32'h0,     1, 1, 32'hA5A5_0001,  32'd1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 32'h100C, 32'h0,          0, 32'h0,     0, 1, 32'hA5A5_0001,  32'd1, 0, 0);
        vecs[10] = mk(0, 0, 1, 32'h1010, 32'hFC00_0000,  1, 32'h1010,  1, 0, 32'hA5A5_0001,  32'd2, 0, 0);
        vecs[11] = mk(0, 0, 0, 32'h1010, 32'h0,          0, 32'h0,     1, 1, 32'hFC00_0000,  32'd2, 0, 0);
        vecs[12] = mk(1, 0, 1, 32'h1014, 32'h0,          0, 32'h0,     1, 0, 32'hFC00_0000,  32'd3, 1, 0);
        vecs[13] = mk(0, 0, 1, 32'h1018, 32'h1234_5678,  0, 32'h0,     1, 0, 32'hFC00_0000,  32'd3, 1, 0);
        vecs[14] = mk(1, 0, 0, 32'h101C, 32'h0,          0, 32'h0,     1, 0, 32'hFC00_0000,  32'd3, 1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        #1 check_outs("reset", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 0);
        reset = 1'b0;

        // Table: fetch, stall, halt
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].start, vecs[i].stall, vecs[i].ack, vecs[i].pc, vecs[i].rdata);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_hold,
                          vecs[i].e_iv, vecs[i].e_instr, vecs[i].e_cnt, vecs[i].e_halt, vecs[i].e_terr);
        end

        // Asynchronous reset out of HALT clears everything without a clock edge
        @(negedge clk);
        drive(0, 0, 0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1 check_outs("async_rst", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 0);

        // Reset mid-REQ, then a late ack must be ignored in IDLE
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 32'h2000, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 32'h2000, 32'h0);
        #1 check_outs("midreq_req", 1, 32'h2000, 1, 0, 32'h0, 32'd0, 0, 0);
        #1 reset = 1'b1;
        #1 check_outs("midreq_rst", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 0);
        chk("midreq_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 32'h2000, 32'h1234_5678);
        #1 check_outs("late_ack", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 0);
        @(negedge clk);
        #1 check_outs("late_ack2", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 0);
        chk("late_ack_state", 32'(dut.state), 32'(ST_IDLE));

        // Timeout: 64 REQ cycles with no ack, then sticky error
        @(negedge clk);
        drive(1, 0, 0, 32'h3000, 32'h0);
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 32'h3000, 32'h0);
            #1 check_outs($sformatf("to_wait%0d", c), 1, 32'h3000, 1, 0, 32'h0, 32'd0, 0, 0);
        end
        @(negedge clk);
        drive(1, 0, 1, 32'h3000, 32'h5555_5555);
        #1 check_outs("to_err", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 1);
        @(negedge clk);
        #1 check_outs("to_err_sticky", 0, 32'h0, 1, 0, 32'h0, 32'd0, 0, 1);

        // Ack on the 64th REQ cycle wins over the timeout
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 32'h3000, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 0, 0, 32'h3000, 32'h0);
        for (int c = 1; c <= 63; c++) begin
            @(negedge clk);
            drive(0, 0, 0, 32'h3000, 32'h0);
        end
        @(negedge clk);
        drive(0, 0, 1, 32'h3000, 32'h0000_0042);
        #1 check_outs("ack64", 1, 32'h3000, 1, 0, 32'h0, 32'd0, 0, 0);
        @(negedge clk);
        drive(0, 1, 0, 32'h3000, 32'h0);
        #1 check_outs("ack64_issue", 0, 32'h0, 1, 1, 32'h0000_0042, 32'd0, 0, 0);

        // Retire counter wraps from all-ones to zero
        @(negedge clk);
        drive(0, 0, 0, 32'h3004, 32'h0);
        force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        #1 begin
            vectors++;
            chk("wrap_retire.pc_hold", 32'(pc_hold), 32'd0);
            chk("wrap_retire.instr_valid", 32'(instr_valid), 32'd1);
        end
        @(negedge clk);
        #1 check_outs("wrap_post", 1, 32'h3004, 1, 0, 32'h0000_0042, 32'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
